// File: rtl/mem_requester.sv
// mem_requester
//   Initiator for the RAM request/return interface. Accepts single-beat client
//   reads/writes, issues one-cycle rd_en/wr_en pulses to the RAM, keeps a small
//   table of outstanding reads and writes keyed by address (the address doubles
//   as the return tag), and matches out-of-order acks back to their entries.
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   cpu_valid/cpu_ready/cpu_we     client request handshake (ready is combinational)
//   cpu_addr/cpu_wdata             client request address / write data
//   resp_valid/resp_addr/resp_rdata  one-cycle read completion
//   wr_done                        one-cycle write completion
//   wr_en/wr_address/wr_data       RAM write request
//   wr_ret_ack/wr_ret_address      RAM write ack + tag
//   rd_en/rd_address               RAM read request
//   rd_ret_ack/rd_ret_address/rd_ret_data  RAM read ack + tag + data
//   rd_outstanding                 number of valid read entries
//   err_unmatched/err_timeout      sticky error flags
module mem_requester #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MAX_RD  = 4,
  parameter int MAX_WR  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cpu_valid,
  output logic                        cpu_ready,
  input  logic                        cpu_we,
  input  logic [ADDR_W-1:0]           cpu_addr,
  input  logic [DATA_W-1:0]           cpu_wdata,
  output logic                        resp_valid,
  output logic [ADDR_W-1:0]           resp_addr,
  output logic [DATA_W-1:0]           resp_rdata,
  output logic                        wr_done,
  output logic [ADDR_W-1:0]           wr_address,
  output logic                        wr_en,
  output logic [DATA_W-1:0]           wr_data,
  input  logic [ADDR_W-1:0]           wr_ret_address,
  input  logic                        wr_ret_ack,
  output logic [ADDR_W-1:0]           rd_address,
  output logic                        rd_en,
  input  logic [DATA_W-1:0]           rd_ret_data,
  input  logic [ADDR_W-1:0]           rd_ret_address,
  input  logic                        rd_ret_ack,
  output logic [$clog2(MAX_RD+1)-1:0] rd_outstanding,
  output logic                        err_unmatched,
  output logic                        err_timeout
);

  localparam int CNT_W = $clog2(MAX_RD+1);
  localparam int AGE_W = $clog2(TIMEOUT+1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT);

  // Outstanding tables
  logic [MAX_RD-1:0] rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0] rd_addr_q [MAX_RD];
  logic [ADDR_W-1:0] rd_addr_d [MAX_RD];
  logic [AGE_W-1:0]  rd_age_q  [MAX_RD];
  logic [AGE_W-1:0]  rd_age_d  [MAX_RD];
  logic [MAX_WR-1:0] wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0] wr_addr_q [MAX_WR];
  logic [ADDR_W-1:0] wr_addr_d [MAX_WR];
  logic [AGE_W-1:0]  wr_age_q  [MAX_WR];
  logic [AGE_W-1:0]  wr_age_d  [MAX_WR];

  // Output registers
  logic              rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] rd_address_q, rd_address_d, wr_address_q, wr_address_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              resp_valid_q, resp_valid_d, wr_done_q, wr_done_d;
  logic [ADDR_W-1:0] resp_addr_q, resp_addr_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              err_unmatched_q, err_unmatched_d;
  logic              err_timeout_q, err_timeout_d;

  // Per-entry match/alloc/free vectors
  logic [MAX_RD-1:0] rd_addr_hit, rd_ack_hit, rd_alloc_oh, rd_alloc, rd_fire, rd_to;
  logic [MAX_WR-1:0] wr_addr_hit, wr_ack_hit, wr_alloc_oh, wr_alloc, wr_fire, wr_to;
  logic accept, rd_accept, wr_accept, rd_fire_any, wr_fire_any;

  // Lowest clear bit of the valid vector, as a one-hot
  assign rd_alloc_oh = ~rd_valid_q & (rd_valid_q + MAX_RD'(1));
  assign wr_alloc_oh = ~wr_valid_q & (wr_valid_q + MAX_WR'(1));

  // Addresses are unique across both tables, so a new request may only go out
  // when nothing in flight uses the same address; only registered state is used,
  // so an entry freed this edge is reusable from the next cycle.
  assign cpu_ready = ~(|rd_addr_hit) & ~(|wr_addr_hit) &
                     (cpu_we ? ~(&wr_valid_q) : ~(&rd_valid_q));
  assign accept    = cpu_valid & cpu_ready;
  assign rd_accept = accept & ~cpu_we;
  assign wr_accept = accept & cpu_we;
  assign rd_alloc  = rd_accept ? rd_alloc_oh : '0;
  assign wr_alloc  = wr_accept ? wr_alloc_oh : '0;
  assign rd_fire   = rd_ret_ack ? rd_ack_hit : '0;
  assign wr_fire   = wr_ret_ack ? wr_ack_hit : '0;
  assign rd_fire_any = |rd_fire;
  assign wr_fire_any = |wr_fire;

  for (genvar gi = 0; gi < MAX_RD; gi++) begin : g_rd
    assign rd_addr_hit[gi] = rd_valid_q[gi] && (rd_addr_q[gi] == cpu_addr);
    assign rd_ack_hit[gi]  = rd_valid_q[gi] && (rd_addr_q[gi] == rd_ret_address);
    assign rd_addr_d[gi]   = rd_alloc[gi] ? cpu_addr : rd_addr_q[gi];
    assign rd_age_d[gi]    = rd_alloc[gi] ? '0 :
                             (rd_valid_q[gi] && rd_age_q[gi] != AGE_MAX) ?
                             rd_age_q[gi] + AGE_W'(1) : rd_age_q[gi];
    // Entry still waiting after this edge with its age at the limit
    assign rd_to[gi] = rd_valid_q[gi] && !rd_fire[gi] && (rd_age_d[gi] == AGE_MAX);
  end

  for (genvar gi = 0; gi < MAX_WR; gi++) begin : g_wr
    assign wr_addr_hit[gi] = wr_valid_q[gi] && (wr_addr_q[gi] == cpu_addr);
    assign wr_ack_hit[gi]  = wr_valid_q[gi] && (wr_addr_q[gi] == wr_ret_address);
    assign wr_addr_d[gi]   = wr_alloc[gi] ? cpu_addr : wr_addr_q[gi];
    assign wr_age_d[gi]    = wr_alloc[gi] ? '0 :
                             (wr_valid_q[gi] && wr_age_q[gi] != AGE_MAX) ?
                             wr_age_q[gi] + AGE_W'(1) : wr_age_q[gi];
    assign wr_to[gi] = wr_valid_q[gi] && !wr_fire[gi] && (wr_age_d[gi] == AGE_MAX);
  end

  // Allocated and freed entries are always disjoint (alloc picks an invalid slot)
  assign rd_valid_d = (rd_valid_q | rd_alloc) & ~rd_fire;
  assign wr_valid_d = (wr_valid_q | wr_alloc) & ~wr_fire;
  assign rd_cnt_d   = rd_cnt_q + CNT_W'(rd_accept) - CNT_W'(rd_fire_any);

  assign rd_en_d      = rd_accept;
  assign wr_en_d      = wr_accept;
  assign rd_address_d = rd_accept ? cpu_addr  : rd_address_q;
  assign wr_address_d = wr_accept ? cpu_addr  : wr_address_q;
  assign wr_data_d    = wr_accept ? cpu_wdata : wr_data_q;

  assign resp_valid_d = rd_fire_any;
  assign resp_addr_d  = rd_fire_any ? rd_ret_address : resp_addr_q;
  assign resp_rdata_d = rd_fire_any ? rd_ret_data    : resp_rdata_q;
  assign wr_done_d    = wr_fire_any;

  assign err_unmatched_d = err_unmatched_q | (rd_ret_ack & ~(|rd_ack_hit))
                                           | (wr_ret_ack & ~(|wr_ack_hit));
  assign err_timeout_d   = err_timeout_q | (|rd_to) | (|wr_to);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q      <= '0;
      wr_valid_q      <= '0;
      for (int i = 0; i < MAX_RD; i++) begin
        rd_addr_q[i] <= '0;
        rd_age_q[i]  <= '0;
      end
      for (int i = 0; i < MAX_WR; i++) begin
        wr_addr_q[i] <= '0;
        wr_age_q[i]  <= '0;
      end
      rd_en_q         <= 1'b0;
      wr_en_q         <= 1'b0;
      rd_address_q    <= '0;
      wr_address_q    <= '0;
      wr_data_q       <= '0;
      resp_valid_q    <= 1'b0;
      resp_addr_q     <= '0;
      resp_rdata_q    <= '0;
      wr_done_q       <= 1'b0;
      rd_cnt_q        <= '0;
      err_unmatched_q <= 1'b0;
      err_timeout_q   <= 1'b0;
    end else begin
      rd_valid_q      <= rd_valid_d;
      wr_valid_q      <= wr_valid_d;
      for (int i = 0; i < MAX_RD; i++) begin
        rd_addr_q[i] <= rd_addr_d[i];
        rd_age_q[i]  <= rd_age_d[i];
      end
      for (int i = 0; i < MAX_WR; i++) begin
        wr_addr_q[i] <= wr_addr_d[i];
        wr_age_q[i]  <= wr_age_d[i];
      end
      rd_en_q         <= rd_en_d;
      wr_en_q         <= wr_en_d;
      rd_address_q    <= rd_address_d;
      wr_address_q    <= wr_address_d;
      wr_data_q       <= wr_data_d;
      resp_valid_q    <= resp_valid_d;
      resp_addr_q     <= resp_addr_d;
      resp_rdata_q    <= resp_rdata_d;
      wr_done_q       <= wr_done_d;
      rd_cnt_q        <= rd_cnt_d;
      err_unmatched_q <= err_unmatched_d;
      err_timeout_q   <= err_timeout_d;
    end
  end

  assign rd_en          = rd_en_q;
  assign wr_en          = wr_en_q;
  assign rd_address     = rd_address_q;
  assign wr_address     = wr_address_q;
  assign wr_data        = wr_data_q;
  assign resp_valid     = resp_valid_q;
  assign resp_addr      = resp_addr_q;
  assign resp_rdata     = resp_rdata_q;
  assign wr_done        = wr_done_q;
  assign rd_outstanding = rd_cnt_q;
  assign err_unmatched  = err_unmatched_q;
  assign err_timeout    = err_timeout_q;

endmodule
